// File: rtl/iomem_timer_pkg.sv
// iomem_timer_pkg
//   Shared constants for the iomem timer peripheral: the address window,
//   register offsets (word index taken from iomem_addr[4:2]), CTRL and
//   STATUS bit positions, and a byte-lane write-merge helper.
package iomem_timer_pkg;

  localparam logic [7:0] BASE_HI_DEFAULT = 8'h04;

  // Register word offsets (iomem_addr[4:2])
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_RELOAD   = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  // CTRL bit indices
  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;

  // STATUS bit indices
  localparam int STATUS_EXP = 0;

  // Replace each byte of old_val whose strobe is set with the matching
  // byte of wdata.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/iomem_timer_prescaler.sv
// iomem_timer_prescaler
//   Divides clk down to a tick strobe for the main counter.
//   Ports:
//     clk, reset : system clock, asynchronous active-high reset
//     enable     : counter runs while high, holds while low
//     load       : force pre_cnt to prescale (used when the timer is enabled)
//     prescale   : reload value; sampled only when pre_cnt reloads, so a
//                  new value never disturbs an in-flight count
//     tick       : high for one cycle when enable=1 and pre_cnt has reached 0
module iomem_timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_cnt;

  assign tick = enable & (pre_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (load || tick) begin
      pre_cnt <= prescale;
    end else if (enable) begin
      pre_cnt <= pre_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/iomem_timer.sv
// iomem_timer
//   32-bit down-counting timer with level interrupt on the picosoc iomem bus.
//   Ports:
//     clk, reset   : system clock, asynchronous active-high reset
//     iomem_valid  : bus request
//     iomem_ready  : one-cycle acknowledge, the cycle after the request is taken
//     iomem_wstrb  : byte write strobes, 0 = read
//     iomem_addr   : byte address; [31:24] selects the window, [4:2] the register
//     iomem_wdata  : write data
//     iomem_rdata  : register value sampled when the request was taken
//     irq          : registered STATUS.expired & CTRL.irq_en
//
//   Handshake: a request is taken on a clock edge where iomem_valid=1,
//   iomem_ready=0 and the address is in our window. On that edge any write is
//   applied and the pre-write register value is captured; the next cycle
//   iomem_ready=1 with iomem_rdata valid, then ready drops. Requests outside
//   the window are never acknowledged by this block.
module iomem_timer
  import iomem_timer_pkg::*;
#(
  parameter logic [7:0] BASE_HI    = BASE_HI_DEFAULT,
  parameter int         PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  logic [2:0]            ctrl_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [31:0]           count_q;
  logic [31:0]           reload_q;
  logic                  expired_q;

  logic [2:0]            ctrl_d;
  logic [PRESCALE_W-1:0] prescale_d;
  logic [31:0]           count_d;
  logic [31:0]           reload_d;
  logic                  expired_d;
  logic [31:0]           rdata_d;

  logic       sel;
  logic       wr;
  logic [2:0] offs;
  logic       wr_ctrl, wr_prescale, wr_count, wr_reload, wr_status;
  logic       tick;
  logic       expire;
  logic       pre_load;
  logic       unused_addr;

  assign unused_addr = ^{iomem_addr[23:5], iomem_addr[1:0]};

  assign sel  = iomem_valid & ~iomem_ready & (iomem_addr[31:24] == BASE_HI);
  assign wr   = sel & (iomem_wstrb != 4'b0000);
  assign offs = iomem_addr[4:2];

  assign wr_ctrl     = wr & (offs == REG_CTRL);
  assign wr_prescale = wr & (offs == REG_PRESCALE);
  assign wr_count    = wr & (offs == REG_COUNT);
  assign wr_reload   = wr & (offs == REG_RELOAD);
  assign wr_status   = wr & (offs == REG_STATUS);

  // Restart the prescaler only on a 0->1 transition of enable via the bus.
  assign pre_load = wr_ctrl & iomem_wstrb[0] & iomem_wdata[CTRL_EN] & ~ctrl_q[CTRL_EN];

  iomem_timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (ctrl_q[CTRL_EN]),
    .load     (pre_load),
    .prescale (prescale_q),
    .tick     (tick)
  );

  assign expire = tick & (count_q == 32'd0);

  // Timer events are applied first, bus writes afterwards so the bus wins
  // every collision except STATUS, where a new expiry beats the clear.
  always_comb begin
    ctrl_d = ctrl_q;
    if (expire && !ctrl_q[CTRL_AUTO]) ctrl_d[CTRL_EN] = 1'b0;
    if (wr_ctrl && iomem_wstrb[0]) ctrl_d = iomem_wdata[2:0];

    prescale_d = prescale_q;
    if (wr_prescale) begin
      for (int b = 0; b < PRESCALE_W; b++) begin
        if (iomem_wstrb[b/8]) prescale_d[b] = iomem_wdata[b];
      end
    end

    count_d = count_q;
    if (tick) begin
      if (count_q != 32'd0)         count_d = count_q - 32'd1;
      else if (ctrl_q[CTRL_AUTO])   count_d = reload_q;
    end
    if (wr_count) count_d = apply_wstrb(count_q, iomem_wdata, iomem_wstrb);

    reload_d = reload_q;
    if (wr_reload) reload_d = apply_wstrb(reload_q, iomem_wdata, iomem_wstrb);

    expired_d = expired_q;
    if (wr_status && iomem_wstrb[0] && iomem_wdata[STATUS_EXP]) expired_d = 1'b0;
    if (expire) expired_d = 1'b1;

    case (offs)
      REG_CTRL:     rdata_d = {29'd0, ctrl_q};
      REG_PRESCALE: rdata_d = 32'(prescale_q);
      REG_COUNT:    rdata_d = count_q;
      REG_RELOAD:   rdata_d = reload_q;
      REG_STATUS:   rdata_d = {31'd0, expired_q};
      default:      rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q      <= '0;
      prescale_q  <= '0;
      count_q     <= '0;
      reload_q    <= '0;
      expired_q   <= 1'b0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      irq         <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      prescale_q  <= prescale_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      expired_q   <= expired_d;
      iomem_ready <= sel;
      iomem_rdata <= sel ? rdata_d : 32'd0;
      irq         <= expired_q & ctrl_q[CTRL_IRQEN];
    end
  end

endmodule

// File: tb/tb_iomem_timer.sv
// tb_iomem_timer
//   Bench for iomem_timer: register table vectors plus hand-written
//   sequences for reset, auto-reload timing, one-shot, collisions and decode.
module tb_iomem_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        irq;

  iomem_timer dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .irq         (irq)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;
  logic [31:0] exp_q[$];

  // ---------------- monitor (ready width, irq rises) ----------------
  int   ready_pulses = 0;
  int   ready_wide   = 0;
  logic prev_ready   = 1'b0;
  logic prev_irq     = 1'b0;
  int   irq_rise_q[$];

  always @(negedge clk) begin
    if (iomem_ready) ready_pulses = ready_pulses + 1;
    if (iomem_ready && prev_ready) ready_wide = ready_wide + 1;
    if (irq && !prev_irq) irq_rise_q.push_back(cyc);
    prev_ready = iomem_ready;
    prev_irq   = irq;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Drives one bus access starting at posedge+1; returns at posedge+1 of the
  // ready cycle. Expected rdata goes into exp_q and is compared when ready
  // appears. chk=0 skips the data compare (ready is still required).
  task automatic bus_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp,
                         input logic chk, input string name);
    logic        got;
    logic [31:0] e;
    exp_q.push_back(exp);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wdata = wdata;
    iomem_wstrb = wstrb;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (iomem_ready) got = 1'b1;
    end
    e = exp_q.pop_front();
    if (!got) begin
      check({name, "_ready_timeout"}, 32'(got), 32'd1);
    end else begin
      n_txn++;
      if (chk) check(name, iomem_rdata, e);
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
  endtask

  task automatic wait_irq_rises(input int k, input string name);
    for (int i = 0; i < 200 && irq_rise_q.size() < k; i++) @(negedge clk);
    check({name, "_timeout"}, 32'(irq_rise_q.size() >= k), 32'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  localparam logic [31:0] A_CTRL = 32'h0400_0000;
  localparam logic [31:0] A_PRE  = 32'h0400_0004;
  localparam logic [31:0] A_CNT  = 32'h0400_0008;
  localparam logic [31:0] A_REL  = 32'h0400_000C;
  localparam logic [31:0] A_STAT = 32'h0400_0010;

  int t0;
  int base;
  int rp0;

  initial begin
    vecs[0]  = '{A_CTRL, 32'h0, 4'h0, 32'h0};
    vecs[1]  = '{A_PRE,  32'h0, 4'h0, 32'h0};
    vecs[2]  = '{A_CNT,  32'h0, 4'h0, 32'h0};
    vecs[3]  = '{A_REL,  32'h0, 4'h0, 32'h0};
    vecs[4]  = '{A_STAT, 32'h0, 4'h0, 32'h0};
    vecs[5]  = '{A_REL,  32'hAABB_CCDD, 4'b0101, 32'h0};
    vecs[6]  = '{A_REL,  32'h0, 4'h0, 32'h00BB_00DD};
    vecs[7]  = '{A_REL,  32'h1111_1111, 4'hF, 32'h00BB_00DD};
    vecs[8]  = '{A_REL,  32'h0, 4'h0, 32'h1111_1111};
    vecs[9]  = '{32'h0400_0018, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[10] = '{32'h0400_0018, 32'h0, 4'h0, 32'h0};
    vecs[11] = '{A_PRE,  32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[12] = '{A_PRE,  32'h0, 4'h0, 32'h0000_FFFF};
    vecs[13] = '{A_CTRL, 32'hFFFF_FFF8, 4'hF, 32'h0};
    vecs[14] = '{A_CTRL, 32'h0, 4'h0, 32'h0};
    vecs[15] = '{A_CTRL, 32'h0000_0006, 4'b0001, 32'h0};
    vecs[16] = '{A_CTRL, 32'h0, 4'h0, 32'h6};
    vecs[17] = '{A_CTRL, 32'h0, 4'hF, 32'h6};
    vecs[18] = '{32'h04AB_CDE8, 32'h1234_5678, 4'hF, 32'h0};
    vecs[19] = '{32'h0400_000B, 32'h0, 4'h0, 32'h1234_5678};
    vecs[20] = '{A_STAT, 32'h0, 4'hF, 32'h0};
    vecs[21] = '{A_PRE,  32'h0, 4'hF, 32'h0000_FFFF};

    // ---------------- reset ----------------
    reset       = 1'b1;
    iomem_valid = 1'b0;
    iomem_addr  = '0;
    iomem_wdata = '0;
    iomem_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(iomem_ready), 32'd0);
    check("reset_rdata", iomem_rdata, 32'd0);
    check("reset_irq",   32'(irq), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Reset pulsed on the same cycle a read of COUNT is requested.
    @(posedge clk); #1;
    iomem_valid = 1'b1;
    iomem_addr  = A_CNT;
    reset       = 1'b1;
    @(negedge clk);
    check("rst_midread_ready0", 32'(iomem_ready), 32'd0);
    @(posedge clk); #1;
    check("rst_midread_ready1", 32'(iomem_ready), 32'd0);
    iomem_valid = 1'b0;
    reset       = 1'b0;
    @(posedge clk); #1;
    bus_txn(A_CNT, 32'h0, 4'h0, 32'h0, 1'b1, "rst_reread_count");

    // ---------------- table-driven register vectors ----------------
    for (int i = 0; i < NV; i++) begin
      bus_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp, 1'b1,
              $sformatf("vec%0d", i));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // ---------------- address decode ----------------
    rp0 = ready_pulses;
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_0008;
    iomem_wdata = 32'h0000_DEAD;
    iomem_wstrb = 4'hF;
    repeat (10) @(posedge clk);
    #1;
    check("decode_no_ready", 32'(ready_pulses - rp0), 32'd0);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    @(posedge clk); #1;
    bus_txn(A_CNT, 32'h0, 4'h0, 32'h1234_5678, 1'b1, "decode_count_kept");

    // ---------------- auto-reload: period 20, irq 1 cycle after expiry ----------------
    base = irq_rise_q.size();
    bus_txn(A_PRE, 32'd3, 4'hF, 32'h0, 1'b1, "auto_wr_pre");
    bus_txn(A_REL, 32'd4, 4'hF, 32'h1111_1111, 1'b1, "auto_wr_rel");
    bus_txn(A_CNT, 32'd4, 4'hF, 32'h1234_5678, 1'b1, "auto_wr_cnt");
    bus_txn(A_CTRL, 32'h7, 4'hF, 32'h0, 1'b1, "auto_wr_ctrl");
    t0 = cyc;
    wait_irq_rises(base + 1, "auto_irq1");
    if (irq_rise_q.size() > base)
      check("auto_first_irq_delay", 32'(irq_rise_q[base] - t0), 32'd21);
    bus_txn(A_STAT, 32'h0, 4'h0, 32'h1, 1'b1, "auto_status_set");
    bus_txn(A_STAT, 32'h1, 4'h1, 32'h1, 1'b1, "auto_status_clr");
    @(posedge clk); #1;
    check("auto_irq_dropped", 32'(irq), 32'd0);
    wait_irq_rises(base + 2, "auto_irq2");
    if (irq_rise_q.size() > base + 1)
      check("auto_period1", 32'(irq_rise_q[base+1] - irq_rise_q[base]), 32'd20);
    bus_txn(A_STAT, 32'h1, 4'h1, 32'h1, 1'b1, "auto_status_clr2");
    wait_irq_rises(base + 3, "auto_irq3");
    if (irq_rise_q.size() > base + 2)
      check("auto_period2", 32'(irq_rise_q[base+2] - irq_rise_q[base+1]), 32'd20);
    bus_txn(A_CTRL, 32'h0, 4'hF, 32'h7, 1'b1, "auto_stop");
    bus_txn(A_STAT, 32'h1, 4'h1, 32'h1, 1'b1, "auto_final_clr");
    @(posedge clk); #1;
    check("auto_irq_off", 32'(irq), 32'd0);

    // ---------------- one-shot ----------------
    bus_txn(A_PRE, 32'd0, 4'hF, 32'd3, 1'b1, "os_wr_pre");
    bus_txn(A_CNT, 32'd2, 4'hF, 32'h0, 1'b0, "os_wr_cnt");
    bus_txn(A_CTRL, 32'h1, 4'hF, 32'h0, 1'b1, "os_wr_ctrl");
    bus_txn(A_CNT,  32'h0, 4'h0, 32'd1, 1'b1, "os_count_mid");
    bus_txn(A_STAT, 32'h0, 4'h0, 32'd1, 1'b1, "os_expired");
    bus_txn(A_CTRL, 32'h0, 4'h0, 32'd0, 1'b1, "os_ctrl_cleared");
    bus_txn(A_CNT,  32'h0, 4'h0, 32'd0, 1'b1, "os_count_zero");
    check("os_irq_low", 32'(irq), 32'd0);

    // ---------------- collision: STATUS clear on expiry edge ----------------
    bus_txn(A_STAT, 32'h1, 4'h1, 32'd1, 1'b1, "cs_pre_clr");
    bus_txn(A_CNT,  32'd1, 4'hF, 32'd0, 1'b1, "cs_wr_cnt");
    bus_txn(A_CTRL, 32'h1, 4'hF, 32'd0, 1'b1, "cs_wr_ctrl");
    bus_txn(A_STAT, 32'h1, 4'h1, 32'd0, 1'b1, "cs_clr_on_expiry");
    bus_txn(A_STAT, 32'h0, 4'h0, 32'd1, 1'b1, "cs_set_wins");
    bus_txn(A_STAT, 32'h1, 4'h1, 32'd1, 1'b1, "cs_clr_after");
    bus_txn(A_STAT, 32'h0, 4'h0, 32'd0, 1'b1, "cs_cleared");

    // ---------------- collision: COUNT write on tick edge ----------------
    bus_txn(A_PRE,  32'd3, 4'hF, 32'd0, 1'b1, "ct_wr_pre");
    bus_txn(A_CNT,  32'h1000, 4'hF, 32'd0, 1'b1, "ct_wr_cnt");
    bus_txn(A_CTRL, 32'h1, 4'hF, 32'd0, 1'b1, "ct_wr_ctrl");
    bus_txn(A_CNT,  32'h0, 4'h0, 32'h1000, 1'b1, "ct_before_tick");
    bus_txn(A_CNT,  32'h100, 4'hF, 32'h1000, 1'b1, "ct_wr_on_tick");
    bus_txn(A_CNT,  32'h0, 4'h0, 32'h100, 1'b1, "ct_bus_wins");
    bus_txn(A_CTRL, 32'h0, 4'hF, 32'h1, 1'b1, "ct_stop");

    // ---------------- end-of-run handshake checks ----------------
    @(posedge clk); #1;
    check("ready_pulse_count", 32'(ready_pulses), 32'(n_txn));
    check("ready_width", 32'(ready_wide), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
